// File: rtl/scan_sequencer_pkg.sv
// Shared types and default sizing for the spectrogram scan sequencer.
package scan_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StDwell,
        StHandoff,
        StDone
    } scan_state_t;

    localparam int unsigned DEF_NUM_CH  = 16;
    localparam int unsigned DEF_SEL_W   = 4;
    localparam int unsigned DEF_DWELL_W = 4;
    localparam int unsigned RTC_CH      = 0;

endpackage

// File: rtl/scan_sequencer_if.sv
// Control/handoff bundle between the scan sequencer (master) and its
// trigger source / readout consumer (slave).
interface scan_sequencer_if #(
    parameter int unsigned NUM_CH  = scan_pkg::DEF_NUM_CH,
    parameter int unsigned SEL_W   = scan_pkg::DEF_SEL_W,
    parameter int unsigned DWELL_W = scan_pkg::DEF_DWELL_W
);
    logic               ovf;
    logic [NUM_CH-1:0]  ch_mask;
    logic [DWELL_W-1:0] dwell;
    logic               slot_ready;
    logic               overrun_clr;
    logic [SEL_W-1:0]   selection;
    logic               sl;
    logic               slot_valid;
    logic               frame_done;
    logic               busy;
    logic               overrun;

    modport master (
        input  ovf, ch_mask, dwell, slot_ready, overrun_clr,
        output selection, sl, slot_valid, frame_done, busy, overrun
    );

    modport slave (
        output ovf, ch_mask, dwell, slot_ready, overrun_clr,
        input  selection, sl, slot_valid, frame_done, busy, overrun
    );
endinterface

// File: rtl/scan_sequencer_next_ch.sv
// Priority encoder: lowest set mask bit (first=1) or lowest set bit above cur.
module scan_next_ch
    import scan_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned SEL_W  = DEF_SEL_W
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    input  logic              first,
    output logic [SEL_W-1:0]  nxt_idx,
    output logic              found
);

    // Scan downward so the lowest qualifying index is the last one written.
    always_comb begin
        nxt_idx = '0;
        found   = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (first || (i > int'(cur)))) begin
                nxt_idx = SEL_W'(i);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// Frame scheduler walking enabled channels with programmable dwell and handoff.
// Optional: SCAN_PENDING_TRIGGER_EN queues one trigger that arrives while busy.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int unsigned NUM_CH  = DEF_NUM_CH,
    parameter int unsigned SEL_W   = DEF_SEL_W,
    parameter int unsigned DWELL_W = DEF_DWELL_W
) (
    input logic              clk,
    input logic              reset_n,
    scan_sequencer_if.master bus
);

    scan_state_t        state_q;
    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [NUM_CH-1:0]  mask_q;
    logic [SEL_W-1:0]   sel_q;
    logic               sl_q;
    logic               valid_q;
    logic               done_q;
    logic               overrun_q;
`ifdef SCAN_PENDING_TRIGGER_EN
    logic               pending_q;
`endif

    logic [NUM_CH-1:0]  enc_mask;
    logic               enc_first;
    logic [SEL_W-1:0]   enc_idx;
    logic               enc_found;

    // LOAD searches the live mask because mask_q is only being captured that cycle.
    assign enc_first = (state_q == StLoad);
    assign enc_mask  = enc_first ? bus.ch_mask : mask_q;

    scan_next_ch #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_next_ch (
        .mask    (enc_mask),
        .cur     (sel_q),
        .first   (enc_first),
        .nxt_idx (enc_idx),
        .found   (enc_found)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            dwell_q   <= '0;
            mask_q    <= '0;
            sel_q     <= SEL_W'(RTC_CH);
            sl_q      <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef SCAN_PENDING_TRIGGER_EN
            pending_q <= 1'b0;
`endif
        end else begin
            sl_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    sel_q   <= SEL_W'(RTC_CH);
                    valid_q <= 1'b0;
                    if (bus.ovf) state_q <= StLoad;
                end
                StLoad: begin
                    mask_q  <= bus.ch_mask;
                    dwell_q <= bus.dwell;
`ifdef SCAN_PENDING_TRIGGER_EN
                    pending_q <= 1'b0;
`endif
                    if (enc_found) begin
                        sel_q   <= enc_idx;
                        cnt_q   <= '0;
                        sl_q    <= 1'b1;
                        state_q <= StDwell;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDwell: begin
                    if (cnt_q == dwell_q) begin
                        valid_q <= 1'b1;
                        state_q <= StHandoff;
                    end else begin
                        cnt_q <= cnt_q + DWELL_W'(1);
                    end
                end
                StHandoff: begin
                    if (bus.slot_ready) begin
                        valid_q <= 1'b0;
                        if (enc_found) begin
                            sel_q   <= enc_idx;
                            cnt_q   <= '0;
                            sl_q    <= 1'b1;
                            state_q <= StDwell;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    sel_q <= SEL_W'(RTC_CH);
`ifdef SCAN_PENDING_TRIGGER_EN
                    state_q <= pending_q ? StLoad : StIdle;
`else
                    state_q <= StIdle;
`endif
                end
                default: state_q <= StIdle;
            endcase

            // Set has priority over clear; placed after the case so it overrides LOAD's clear.
            if (bus.ovf && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
`ifdef SCAN_PENDING_TRIGGER_EN
                pending_q <= 1'b1;
`endif
            end else if (bus.overrun_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.selection  = sel_q;
    assign bus.sl         = sl_q;
    assign bus.slot_valid = valid_q;
    assign bus.frame_done = done_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: frame table plus back-pressure, overrun
// and mid-frame reset sequences. Honours SCAN_PENDING_TRIGGER_EN if defined.
module tb_scan_sequencer;

    logic clk;
    logic reset_n;

    scan_sequencer_if bus ();

    scan_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    typedef struct {
        string       name;
        logic [15:0] mask;
        logic [3:0]  dw;
        int          nsl;
        int          done_c;
        logic [63:0] seq;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Starts a frame at a negedge with slot_ready high; returns one cycle after frame_done.
    task automatic run_frame(input string nm, input logic [15:0] m, input logic [3:0] dw,
                             input int nsl, input int done_c, input logic [63:0] seq);
        int k;
        int nv;
        int nfd;
        int dc;
        logic [63:0] s;
        k = 0; nv = 0; nfd = 0; dc = -1; s = seq;
        bus.ch_mask = m; bus.dwell = dw; bus.slot_ready = 1'b1;
        bus.ovf = 1'b1;
        tick();
        bus.ovf = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (bus.sl) begin
                chk({nm, "_sl_cycle"}, c, 2 + k * (int'(dw) + 2));
                if (k < 16) chk({nm, "_sel"}, int'(bus.selection), int'(s[4*k +: 4]));
                k++;
            end
            if (bus.slot_valid) nv++;
            if (bus.frame_done) begin
                nfd++;
                if (dc < 0) dc = c;
            end
            if (c == 2) begin
                bus.ch_mask = ~m;
                bus.dwell   = ~dw;
            end
            if (dc >= 0 && c > dc) break;
            tick();
        end
        chk({nm, "_done_cycle"}, dc, done_c);
        chk({nm, "_sl_count"}, k, nsl);
        chk({nm, "_valid_cycles"}, nv, nsl);
        chk({nm, "_done_width"}, nfd, 1);
        chk({nm, "_idle_after"}, int'(bus.busy), 0);
        bus.ch_mask = m; bus.dwell = dw;
    endtask

    initial begin
        int nv2;
        int bad;
        int sl3;
        int dc;
        int v21;
        int fd;
        vecs[0] = '{"sweep",  16'hFFFF, 4'd11, 16, 210, 64'hFEDC_BA98_7654_3210};
        vecs[1] = '{"sparse", 16'h8421, 4'd3,  4,  22,  64'h0000_0000_0000_FA50};
        vecs[2] = '{"empty",  16'h0000, 4'd5,  0,  2,   64'h0};
        vecs[3] = '{"top",    16'h8000, 4'd0,  1,  4,   64'h0000_0000_0000_000F};
        vecs[4] = '{"rtc",    16'h0001, 4'd15, 1,  19,  64'h0};
        vecs[5] = '{"pair",   16'h0006, 4'd1,  2,  8,   64'h0000_0000_0000_0021};

        reset_n = 1'b0;
        bus.ovf = 1'b0; bus.ch_mask = '0; bus.dwell = '0;
        bus.slot_ready = 1'b1; bus.overrun_clr = 1'b0;
        tick(); tick();
        chk("rst_selection",  int'(bus.selection), 0);
        chk("rst_sl",         int'(bus.sl), 0);
        chk("rst_slot_valid", int'(bus.slot_valid), 0);
        chk("rst_frame_done", int'(bus.frame_done), 0);
        chk("rst_busy",       int'(bus.busy), 0);
        chk("rst_overrun",    int'(bus.overrun), 0);
        reset_n = 1'b1;
        tick();

        foreach (vecs[i])
            run_frame(vecs[i].name, vecs[i].mask, vecs[i].dw, vecs[i].nsl,
                      vecs[i].done_c, vecs[i].seq);

        // Back-pressure: slot 2 handoff stalled for 7 cycles.
        nv2 = 0; bad = 0; sl3 = -1; dc = -1; v21 = -1;
        bus.ch_mask = 16'h000F; bus.dwell = 4'd2; bus.slot_ready = 1'b1;
        bus.ovf = 1'b1;
        tick();
        bus.ovf = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (bus.slot_valid && c >= 13 && c <= 20) begin
                nv2++;
                if (bus.selection != 4'd2) bad++;
            end
            if (c == 21) v21 = int'(bus.slot_valid);
            if (bus.sl && bus.selection == 4'd3 && sl3 < 0) sl3 = c;
            if (bus.frame_done && dc < 0) dc = c;
            bus.slot_ready = (c < 13 || c >= 20);
            if (dc >= 0) break;
            tick();
        end
        chk("bp_valid_cycles", nv2, 8);
        chk("bp_sel_stable_bad", bad, 0);
        chk("bp_valid_dropped", v21, 0);
        chk("bp_slot3_sl_cycle", sl3, 21);
        chk("bp_done_cycle", dc, 25);
        bus.slot_ready = 1'b1;
        tick();

        // Overrun: re-trigger mid-frame, then trigger together with clear.
        bus.ch_mask = 16'h000F; bus.dwell = 4'd2;
        bus.ovf = 1'b1;
        tick();
        bus.ovf = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 1) chk("ovr_idle_trigger_no_set", int'(bus.overrun), 0);
            if (c == 5) chk("ovr_set", int'(bus.overrun), 1);
            if (c == 9) chk("ovr_set_wins", int'(bus.overrun), 1);
            if (c == 18) chk("ovr_frame_done", int'(bus.frame_done), 1);
`ifdef SCAN_PENDING_TRIGGER_EN
            if (c == 19) chk("ovr_pending_busy", int'(bus.busy), 1);
            if (c == 20) begin
                chk("ovr_pending_sl", int'(bus.sl), 1);
                chk("ovr_pending_sel", int'(bus.selection), 0);
            end
`else
            if (c == 19) chk("ovr_back_to_idle", int'(bus.busy), 0);
            if (c == 20) chk("ovr_no_new_sl", int'(bus.sl), 0);
`endif
            bus.ovf         = (c == 4 || c == 8);
            bus.overrun_clr = (c == 8);
            if (c == 20) break;
            tick();
        end
        bus.ovf = 1'b0; bus.overrun_clr = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.busy) break;
            tick();
        end
        chk("ovr_drain_idle", int'(bus.busy), 0);
        chk("ovr_sticky", int'(bus.overrun), 1);
        bus.overrun_clr = 1'b1;
        tick();
        bus.overrun_clr = 1'b0;
        chk("ovr_cleared", int'(bus.overrun), 0);
        tick();

        // Reset during slot 6 of a full sweep.
        fd = 0;
        bus.ch_mask = 16'hFFFF; bus.dwell = 4'd11;
        bus.ovf = 1'b1;
        tick();
        bus.ovf = 1'b0;
        for (int c = 1; c <= 82; c++) begin
            if (bus.frame_done) fd++;
            if (c == 82) break;
            tick();
        end
        chk("mid_sel_before_reset", int'(bus.selection), 6);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_selection",  int'(bus.selection), 0);
        chk("mid_rst_sl",         int'(bus.sl), 0);
        chk("mid_rst_slot_valid", int'(bus.slot_valid), 0);
        chk("mid_rst_frame_done", int'(bus.frame_done), 0);
        chk("mid_rst_busy",       int'(bus.busy), 0);
        chk("mid_rst_overrun",    int'(bus.overrun), 0);
        tick();
        if (bus.frame_done) fd++;
        tick();
        if (bus.frame_done) fd++;
        chk("mid_no_frame_done", fd, 0);
        reset_n = 1'b1;
        tick();
        run_frame("restart", 16'h0003, 4'd0, 2, 6, 64'h0000_0000_0000_0010);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
